// File: rtl/div_arbiter.sv
// Round-robin front end for a shared fixed-latency unsigned divider core, with signed fixup.
// Optional macro DIV_BYPASS_EN resolves trivial divides (b==0, overflow, |a|<|b|, |b|==1) without the core.
module div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ROB_W   = 5,
  parameter int DIV_LAT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*3-1:0]       i_req_funct3,
  input  logic [N_REQ*32-1:0]      i_req_a,
  input  logic [N_REQ*32-1:0]      i_req_b,
  input  logic [N_REQ*ROB_W-1:0]   i_req_rob,
  output logic [N_REQ-1:0]         o_req_ack,
  output logic                     o_dv_start,
  output logic [31:0]              o_dv_a,
  output logic [31:0]              o_dv_b,
  input  logic [31:0]              i_dv_quo,
  input  logic [31:0]              i_dv_rem,
  output logic                     o_res_valid,
  output logic [ROB_W-1:0]         o_res_rob,
  output logic [31:0]              o_res_data,
  input  logic                     i_res_ready
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Signed ops are funct3 1x0; anything else is treated as unsigned.
  function automatic logic [31:0] f_mag(input logic [2:0] op, input logic [31:0] x);
    logic [31:0] m;
    if (op[2] && !op[0] && x[31]) begin
      m = 32'd0 - x;
    end else begin
      m = x;
    end
    return m;
  endfunction

  function automatic logic [31:0] f_fixup(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] quo,
                                          input logic [31:0] rem);
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    sgn = op[2] & ~op[0];
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = (a[31] ^ b[31]) ? (32'd0 - quo) : quo;
      r = a[31] ? (32'd0 - rem) : rem;
    end else begin
      q = quo;
      r = rem;
    end
    return op[1] ? r : q;
  endfunction

  logic [1:0]       r_state;
  logic [PTR_W-1:0] r_rr_ptr;
  logic [3:0]       r_cnt;
  logic [2:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [ROB_W-1:0] r_rob;
  logic             r_dv_start;
  logic [31:0]      r_dv_a;
  logic [31:0]      r_dv_b;
  logic             r_res_valid;
  logic [ROB_W-1:0] r_res_rob;
  logic [31:0]      r_res_data;

  logic [PTR_W-1:0] w_win_idx;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [2:0]       w_win_op;
  logic [31:0]      w_win_a;
  logic [31:0]      w_win_b;
  logic [ROB_W-1:0] w_win_rob;
  logic [31:0]      w_mag_a;
  logic [31:0]      w_mag_b;
  logic             w_grant;

  // Round-robin pick: scanning downward from the farthest slot leaves the first valid one at/after r_rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    w_win_idx = '0;
    w_win_op  = 3'd0;
    w_win_a   = 32'd0;
    w_win_b   = 32'd0;
    w_win_rob = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx       = int'(r_rr_ptr) + i;
      idx       = (idx >= N_REQ) ? (idx - N_REQ) : idx;
      w_win_idx = i_req_valid[idx] ? PTR_W'(idx) : w_win_idx;
      w_win_op  = i_req_valid[idx] ? i_req_funct3[idx*3 +: 3] : w_win_op;
      w_win_a   = i_req_valid[idx] ? i_req_a[idx*32 +: 32] : w_win_a;
      w_win_b   = i_req_valid[idx] ? i_req_b[idx*32 +: 32] : w_win_b;
      w_win_rob = i_req_valid[idx] ? i_req_rob[idx*ROB_W +: ROB_W] : w_win_rob;
    end
  end

  assign w_grant   = (r_state == S_IDLE) & ~i_flush & ~i_rst & (|i_req_valid);
  assign w_ptr_nxt = (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : (w_win_idx + PTR_W'(1));
  assign w_mag_a   = f_mag(w_win_op, w_win_a);
  assign w_mag_b   = f_mag(w_win_op, w_win_b);
  assign o_req_ack = w_grant ? (N_REQ'(1) << w_win_idx) : '0;

`ifdef DIV_BYPASS_EN
  logic        w_ovf;
  logic        w_small;
  logic        w_bypass;
  logic [31:0] w_byp_quo;
  logic [31:0] w_byp_rem;

  // Synthetic core outputs; f_fixup then applies signs and the b==0 / overflow overrides.
  assign w_ovf     = w_win_op[2] & ~w_win_op[0] & (w_win_a == 32'h8000_0000) & (w_win_b == 32'hFFFF_FFFF);
  assign w_small   = (w_mag_a < w_mag_b);
  assign w_bypass  = (w_win_b == 32'd0) | w_ovf | w_small | (w_mag_b == 32'd1);
  assign w_byp_quo = w_small ? 32'd0 : w_mag_a;
  assign w_byp_rem = w_small ? w_mag_a : 32'd0;
`endif

  // Main FSM: capture on grant, pulse the core, count its latency, hold the result until accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_cnt       <= 4'd0;
      r_op        <= 3'd0;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_rob       <= '0;
      r_dv_start  <= 1'b0;
      r_dv_a      <= 32'd0;
      r_dv_b      <= 32'd0;
      r_res_valid <= 1'b0;
      r_res_rob   <= '0;
      r_res_data  <= 32'd0;
    end else if (i_flush) begin
      r_state     <= S_IDLE;
      r_dv_start  <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_rr_ptr <= w_ptr_nxt;
            r_op     <= w_win_op;
            r_a      <= w_win_a;
            r_b      <= w_win_b;
            r_rob    <= w_win_rob;
            r_dv_a   <= w_mag_a;
            r_dv_b   <= w_mag_b;
`ifdef DIV_BYPASS_EN
            if (w_bypass) begin
              r_state     <= S_RESP;
              r_res_valid <= 1'b1;
              r_res_rob   <= w_win_rob;
              r_res_data  <= f_fixup(w_win_op, w_win_a, w_win_b, w_byp_quo, w_byp_rem);
            end else begin
              r_state    <= S_ISSUE;
              r_dv_start <= 1'b1;
            end
`else
            r_state    <= S_ISSUE;
            r_dv_start <= 1'b1;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_dv_start <= 1'b0;
          r_cnt      <= 4'd0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 4'(DIV_LAT - 1)) begin
            r_res_valid <= 1'b1;
            r_res_rob   <= r_rob;
            r_res_data  <= f_fixup(r_op, r_a, r_b, i_dv_quo, i_dv_rem);
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_RESP;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_dv_start  = r_dv_start;
  assign o_dv_a      = r_dv_a;
  assign o_dv_b      = r_dv_b;
  assign o_res_valid = r_res_valid;
  assign o_res_rob   = r_res_rob;
  assign o_res_data  = r_res_data;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed, table-driven bench for div_arbiter with a behavioural fixed-latency divider core.
module tb_div_arbiter;
  localparam int N_REQ   = 4;
  localparam int ROB_W   = 5;
  localparam int DIV_LAT = 4;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*3-1:0]     req_funct3;
  logic [N_REQ*32-1:0]    req_a;
  logic [N_REQ*32-1:0]    req_b;
  logic [N_REQ*ROB_W-1:0] req_rob;
  logic [N_REQ-1:0]       req_ack;
  logic                   dv_start;
  logic [31:0]            dv_a;
  logic [31:0]            dv_b;
  logic [31:0]            dv_quo;
  logic [31:0]            dv_rem;
  logic                   res_valid;
  logic [ROB_W-1:0]       res_rob;
  logic [31:0]            res_data;
  logic                   res_ready;

  int n_cmp = 0;
  int n_bad = 0;

  div_arbiter #(.N_REQ(N_REQ), .ROB_W(ROB_W), .DIV_LAT(DIV_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_req_valid(req_valid), .i_req_funct3(req_funct3), .i_req_a(req_a), .i_req_b(req_b),
    .i_req_rob(req_rob), .o_req_ack(req_ack), .o_dv_start(dv_start), .o_dv_a(dv_a),
    .o_dv_b(dv_b), .i_dv_quo(dv_quo), .i_dv_rem(dv_rem), .o_res_valid(res_valid),
    .o_res_rob(res_rob), .o_res_data(res_data), .i_res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider core stand-in: results valid only exactly DIV_LAT cycles after the start pulse.
  logic [31:0] core_q;
  logic [31:0] core_r;
  int          core_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cnt <= 0; core_q <= 32'd0; core_r <= 32'd0;
    end else if (dv_start) begin
      core_cnt <= 1;
      core_q   <= (dv_b == 32'd0) ? 32'hFFFF_FFFF : dv_a / dv_b;
      core_r   <= (dv_b == 32'd0) ? dv_a : dv_a % dv_b;
    end else if (core_cnt != 0 && core_cnt < DIV_LAT) begin
      core_cnt <= core_cnt + 1;
    end else begin
      core_cnt <= 0;
    end
  end
  assign dv_quo = (core_cnt == DIV_LAT) ? core_q : 32'hDEAD_BEEF;
  assign dv_rem = (core_cnt == DIV_LAT) ? core_r : 32'hBAD0_BAD0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int          unit;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rob;
    logic [31:0] exp_data;
    logic [31:0] exp_dva;
    logic [31:0] exp_dvb;
    bit          byp;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input int u, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rob);
    req_valid[u]            = 1'b1;
    req_funct3[u*3 +: 3]    = op;
    req_a[u*32 +: 32]       = a;
    req_b[u*32 +: 32]       = b;
    req_rob[u*ROB_W +: ROB_W] = rob;
  endtask

  task automatic clr_req(input int u);
    req_valid[u] = 1'b0;
  endtask

  // Called in the ack cycle; follows the transaction up to the first res_valid cycle.
  task automatic finish_txn(input string nm, input int u, input int exp_lat, input bit exp_start,
                            input logic [31:0] eda, input logic [31:0] edb,
                            input logic [31:0] ed, input logic [4:0] er);
    int k;
    bit seen;
    tick();
    clr_req(u);
    k = 1;
    seen = 1'b0;
    while (!res_valid && k < 20) begin
      if (dv_start) begin
        seen = 1'b1;
        chk({nm, "_dv_a"}, dv_a, eda);
        chk({nm, "_dv_b"}, dv_b, edb);
        chk({nm, "_start_cycle"}, 32'(k), 32'd1);
      end
      tick();
      k++;
    end
    chk({nm, "_latency"}, 32'(k), 32'(exp_lat));
    chk({nm, "_start_seen"}, {31'd0, seen}, {31'd0, exp_start});
    chk({nm, "_data"}, res_data, ed);
    chk({nm, "_rob"}, {27'd0, res_rob}, {27'd0, er});
  endtask

  initial begin
    int lat;
    bit st;
    int ng;
    int cyc;
    int nres;
    logic [3:0] got[4];
    logic [3:0] exp_rr[4];

    vecs[0]  = '{2, 3'b100, 32'hFFFF_FFF9, 32'd2,          5'd3,  32'hFFFF_FFFD, 32'd7,          32'd2, 1'b0};
    vecs[1]  = '{0, 3'b110, 32'hFFFF_FFF9, 32'd2,          5'd4,  32'hFFFF_FFFF, 32'd7,          32'd2, 1'b0};
    vecs[2]  = '{1, 3'b111, 32'd7,         32'd0,          5'd5,  32'd7,         32'd7,          32'd0, 1'b1};
    vecs[3]  = '{3, 3'b101, 32'h0000_1234, 32'd0,          5'd6,  32'hFFFF_FFFF, 32'h0000_1234,  32'd0, 1'b1};
    vecs[4]  = '{0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,  5'd7,  32'h8000_0000, 32'h8000_0000,  32'd1, 1'b1};
    vecs[5]  = '{1, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF,  5'd8,  32'd0,         32'h8000_0000,  32'd1, 1'b1};
    vecs[6]  = '{2, 3'b101, 32'd100,       32'd7,          5'd9,  32'd14,        32'd100,        32'd7, 1'b0};
    vecs[7]  = '{3, 3'b111, 32'd100,       32'd7,          5'd10, 32'd2,         32'd100,        32'd7, 1'b0};
    vecs[8]  = '{0, 3'b100, 32'd7,         32'hFFFF_FFFE,  5'd11, 32'hFFFF_FFFD, 32'd7,          32'd2, 1'b0};
    vecs[9]  = '{1, 3'b110, 32'd7,         32'hFFFF_FFFE,  5'd12, 32'd1,         32'd7,          32'd2, 1'b0};
    vecs[10] = '{2, 3'b100, 32'hFFFF_FFF7, 32'hFFFF_FFFC,  5'd13, 32'd2,         32'd9,          32'd4, 1'b0};
    vecs[11] = '{3, 3'b101, 32'd3,         32'd9,          5'd14, 32'd0,         32'd3,          32'd9, 1'b1};
    vecs[12] = '{0, 3'b100, 32'hFFFF_FFFB, 32'd1,          5'd15, 32'hFFFF_FFFB, 32'd5,          32'd1, 1'b1};
    vecs[13] = '{1, 3'b101, 32'hFFFF_FFFF, 32'd2,          5'd16, 32'h7FFF_FFFF, 32'hFFFF_FFFF,  32'd2, 1'b0};

    rst = 1'b1; flush = 1'b0; res_ready = 1'b1;
    req_valid = '0; req_funct3 = '0; req_a = '0; req_b = '0; req_rob = '0;
    set_req(0, 3'b101, 32'd9, 32'd3, 5'd1);
    tick();
    tick();
    chk("rst_ack", {28'd0, req_ack}, 32'd0);
    chk("rst_dv_start", {31'd0, dv_start}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_rob", {27'd0, res_rob}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_dv_a", dv_a, 32'd0);
    chk("rst_dv_b", dv_b, 32'd0);
    clr_req(0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      tick();
      set_req(vecs[i].unit, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rob);
      #1;
      chk($sformatf("v%0d_ack", i), {28'd0, req_ack}, 32'(1 << vecs[i].unit));
`ifdef DIV_BYPASS_EN
      lat = vecs[i].byp ? 1 : 2 + DIV_LAT;
      st  = !vecs[i].byp;
`else
      lat = 2 + DIV_LAT;
      st  = 1'b1;
`endif
      finish_txn($sformatf("v%0d", i), vecs[i].unit, lat, st, vecs[i].exp_dva, vecs[i].exp_dvb,
                 vecs[i].exp_data, vecs[i].rob);
    end

    // Flush in WAIT with res_ready=1: the flushed result never shows, the waiting request goes next.
    tick();
    set_req(1, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd20);
    #1;
    chk("fl_first_ack", {28'd0, req_ack}, 32'd2);
    tick();
    clr_req(1);
    tick();
    set_req(2, 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd21);
    flush = 1'b1;
    #1;
    chk("fl_flush_cycle_ack", {28'd0, req_ack}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_next_ack", {28'd0, req_ack}, 32'd4);
    chk("fl_no_valid", {31'd0, res_valid}, 32'd0);
    finish_txn("fl_next", 2, 2 + DIV_LAT, 1'b1, 32'd7, 32'd2, 32'hFFFF_FFFF, 5'd21);

    // Back-pressure: result held for 3 cycles, no ack until the cycle after acceptance.
    tick();
    res_ready = 1'b0;
    set_req(0, 3'b101, 32'd50, 32'd5, 5'd9);
    #1;
    chk("st_ack", {28'd0, req_ack}, 32'd1);
    finish_txn("st", 0, 2 + DIV_LAT, 1'b1, 32'd50, 32'd5, 32'd10, 5'd9);
    set_req(3, 3'b101, 32'd8, 32'd2, 5'd11);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("st_hold%0d_valid", c), {31'd0, res_valid}, 32'd1);
      chk($sformatf("st_hold%0d_rob", c), {27'd0, res_rob}, 32'd9);
      chk($sformatf("st_hold%0d_data", c), res_data, 32'd10);
      chk($sformatf("st_hold%0d_ack", c), {28'd0, req_ack}, 32'd0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    chk("st_accept_ack", {28'd0, req_ack}, 32'd0);
    chk("st_accept_valid", {31'd0, res_valid}, 32'd1);
    tick();
    chk("st_after_valid", {31'd0, res_valid}, 32'd0);
    chk("st_after_ack", {28'd0, req_ack}, 32'd8);
    finish_txn("st_next", 3, 2 + DIV_LAT, 1'b1, 32'd8, 32'd2, 32'd4, 5'd11);

    // Reset mid-divide: outputs clear and no result is ever emitted.
    tick();
    set_req(3, 3'b101, 32'd100, 32'd7, 5'd12);
    #1;
    chk("mr_ack", {28'd0, req_ack}, 32'd8);
    tick();
    clr_req(3);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mr_dv_start", {31'd0, dv_start}, 32'd0);
    chk("mr_res_data", res_data, 32'd0);
    chk("mr_dv_a", dv_a, 32'd0);
    tick();
    rst = 1'b0;
    nres = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (res_valid) nres++;
    end
    chk("mr_no_result", 32'(nres), 32'd0);

    // Round robin: one grant to unit 0 moves rr_ptr to 1, then units 0,1,3 request continuously.
    tick();
    set_req(0, 3'b101, 32'd9, 32'd3, 5'd1);
    #1;
    chk("rr_seed_ack", {28'd0, req_ack}, 32'd1);
    finish_txn("rr_seed", 0, 2 + DIV_LAT, 1'b1, 32'd9, 32'd3, 32'd3, 5'd1);
    tick();
    set_req(0, 3'b101, 32'd9, 32'd3, 5'd1);
    set_req(1, 3'b101, 32'd9, 32'd3, 5'd2);
    set_req(3, 3'b101, 32'd9, 32'd3, 5'd3);
    #1;
    exp_rr[0] = 4'b0010; exp_rr[1] = 4'b1000; exp_rr[2] = 4'b0001; exp_rr[3] = 4'b0010;
    ng = 0;
    cyc = 0;
    while (ng < 4 && cyc < 200) begin
      if (req_ack != 4'd0) begin
        got[ng] = req_ack;
        ng++;
      end
      tick();
      cyc++;
    end
    chk("rr_grant_count", 32'(ng), 32'd4);
    for (int g = 0; g < 4; g++) begin
      if (g < ng) chk($sformatf("rr_grant%0d", g), {28'd0, got[g]}, {28'd0, exp_rr[g]});
    end
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
